// File: rtl/pdm_pkg.sv
// Shared constants and derived widths for the PDM-to-PCM filter chain.
package pdm_pkg;

   localparam int WIN      = 255;
   localparam int OUT_W    = 8;
   localparam int DEC_NUM  = 11;
   localparam int DEC_DEN  = 16;
   localparam int AVG_TAPS = 4;

   localparam int PH_W  = $clog2(DEC_DEN);
   localparam int ACC_W = OUT_W + $clog2(AVG_TAPS);

endpackage

// File: rtl/pdm_frac_strobe.sv
// Fractional-rate strobe: phase accumulator that fires DEC_NUM times per DEC_DEN clocks.
module pdm_frac_strobe
   import pdm_pkg::*;
(
   input  logic clk,
   input  logic rst,
   output logic stb
);

   logic [PH_W-1:0] p;
   logic [PH_W:0]   p_sum;

   // One extra bit keeps the wrap visible; it is exactly the strobe.
   assign p_sum = {1'b0, p} + (PH_W+1)'(DEC_NUM);
   assign stb   = (p_sum >= (PH_W+1)'(DEC_DEN));

   always_ff @(posedge clk) begin
      if (rst) begin
         p <= '0;
      end else begin
         p <= p_sum[PH_W-1:0];
      end
   end

endmodule

// File: rtl/pdm_filter.sv
// PDM bitstream to PCM: 255-bit boxcar, 11/16 fractional decimator, 4-tap average.
module pdm_filter
   import pdm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   output logic [OUT_W-1:0] out
);

   logic [WIN-1:0]   win;
   logic [OUT_W-1:0] s;
   logic [OUT_W-1:0] s_next;
   logic [OUT_W-1:0] h0, h1, h2, h3;
   logic             hist_upd;
   logic             stb;
   logic [ACC_W-1:0] hist_sum;

   pdm_frac_strobe u_strobe (
      .clk (clk),
      .rst (rst),
      .stb (stb)
   );

   // Running ones-count: only the bit entering and the bit leaving matter.
   always_comb begin
      s_next = s;
      if (in && !win[WIN-1]) begin
         s_next = s + OUT_W'(1);
      end else if (!in && win[WIN-1]) begin
         s_next = s - OUT_W'(1);
      end
   end

   assign hist_sum = ACC_W'(h0) + ACC_W'(h1) + ACC_W'(h2) + ACC_W'(h3);

   always_ff @(posedge clk) begin
      if (rst) begin
         win      <= '0;
         s        <= '0;
         h0       <= '0;
         h1       <= '0;
         h2       <= '0;
         h3       <= '0;
         hist_upd <= 1'b0;
         out      <= '0;
      end else begin
         win      <= {win[WIN-2:0], in};
         s        <= s_next;
         hist_upd <= stb;
         if (stb) begin
            h3 <= h2;
            h2 <= h1;
            h1 <= h0;
            h0 <= s;
         end
         // Dropping the low bits is the truncating divide by AVG_TAPS.
         if (hist_upd) begin
            out <= hist_sum[ACC_W-1:ACC_W-OUT_W];
         end
      end
   end

endmodule

// File: tb/tb_pdm_filter.sv
// Directed bench for pdm_filter with a per-cycle reference model and expected-value queue.
module tb_pdm_filter;

   logic       clk;
   logic       rst;
   logic       in;
   logic [7:0] out;

   pdm_filter dut (
      .clk (clk),
      .rst (rst),
      .in  (in),
      .out (out)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // bookkeeping
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int stb_cnt  = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // reference model
   bit         hist[$];
   int         ecount;
   logic [7:0] mh[4];
   logic       mupd;
   logic [7:0] mout;
   logic       m_stb;

   task automatic model_step(input logic b, input logic r);
      int s_pre;
      logic [9:0] acc;
      if (r) begin
         hist.delete();
         ecount = 0;
         for (int i = 0; i < 4; i++) mh[i] = 8'd0;
         mupd  = 1'b0;
         mout  = 8'd0;
         m_stb = 1'b0;
      end else begin
         s_pre = 0;
         foreach (hist[i]) s_pre += int'(hist[i]);
         m_stb = (((11 * ecount) % 16) >= 5);
         if (mupd) begin
            acc  = 10'(mh[0]) + 10'(mh[1]) + 10'(mh[2]) + 10'(mh[3]);
            mout = acc[9:2];
         end
         mupd = m_stb;
         if (m_stb) begin
            mh[3] = mh[2];
            mh[2] = mh[1];
            mh[1] = mh[0];
            mh[0] = 8'(s_pre);
         end
         hist.push_back(b);
         if (hist.size() > 255) void'(hist.pop_front());
         ecount++;
      end
      exp_q.push_back(mout);
   endtask

   // driver: apply one edge, then compare strobe and output against the model
   task automatic drive(input logic b, input logic r);
      logic stb_pre;
      logic [7:0] e;
      in  = b;
      rst = r;
      stb_pre = dut.stb;
      @(posedge clk);
      #1;
      model_step(b, r);
      if (r) begin
         cyc = 0;
         stb_cnt = 0;
      end else begin
         cyc++;
         if (stb_pre) stb_cnt++;
         check("stb", stb_pre, m_stb);
      end
      e = exp_q.pop_front();
      check("out", out, e);
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b1);
      check("reset_out", out, 0);
      check("reset_phase", dut.u_strobe.p, 0);
   endtask

   task automatic run_ones(input string tag);
      logic [7:0] prev;
      prev = 8'd0;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'b0);
         check({tag, "_mono"}, (out >= prev), 1);
         prev = out;
         if (cyc >= 265) check({tag, "_full"}, out, 255);
      end
   endtask

   logic [127:0] base_word;
   logic [127:0] word;

   initial begin
      rst = 1'b1;
      in  = 1'b0;
      model_step(1'b0, 1'b1);
      void'(exp_q.pop_front());

      drive(1'b0, 1'b1);
      do_reset();

      // constant zero
      for (int i = 0; i < 600; i++) begin
         drive(1'b0, 1'b0);
         check("zero_out", out, 0);
      end

      // constant one
      do_reset();
      run_ones("ones");

      // mid-stream reset after full scale, then the same settling again
      do_reset();
      run_ones("ones_again");

      // alternating 1,0
      do_reset();
      for (int i = 0; i < 1000; i++) begin
         drive(((i % 2) == 0), 1'b0);
         if (cyc >= 300) check("alt_settled", out, 127);
      end
      check("alt_final", out, 127);

      // strobe cadence
      do_reset();
      for (int i = 0; i < 1600; i++) begin
         drive(1'($urandom_range(0, 1)), 1'b0);
         if (cyc == 1) check("first_edge_no_stb", stb_cnt, 0);
         if (cyc == 2) check("second_edge_stb", stb_cnt, 1);
      end
      check("stb_count_1600", stb_cnt, 1100);

      // shifted 128-bit words, MSB first
      do_reset();
      base_word = 128'h02FF37ABC326A7202381F0FF2A23F6BE;
      for (int k = 0; k < 8; k++) begin
         case (k)
            0: word = base_word;
            1: word = {base_word[114:0], base_word[127:115]};
            2: word = {base_word[98:0],  base_word[127:99]};
            3: word = {base_word[63:0],  base_word[127:64]};
            4: word = ~base_word;
            5: word = base_word << 7;
            6: word = base_word >> 11;
            default: word = {base_word[0 +: 64], base_word[64 +: 64]} ^ {4{32'hFFFF0000}};
         endcase
         for (int i = 127; i >= 0; i--) begin
            drive(word[i], 1'b0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
